// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register of the 5-stage core.
// It captures the operands, immediate, PC and decoded control of the instruction in ID,
// and presents them to EX one cycle later. It also detects load-use hazards against the
// instruction in EX, and applies branch flush and downstream hold.
// Optional feature: define ID_EX_PERF_EN to get a load-use bubble counter on bubble_cnt_o.
`timescale 1ns/1ps

module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4,
  parameter int PERF_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [RADDR_W-1:0]   id_rs1_i,
  input  logic [RADDR_W-1:0]   id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [RADDR_W-1:0]   id_rd_i,
  input  logic [XLEN-1:0]      id_rdata1_i,
  input  logic [XLEN-1:0]      id_rdata2_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic [7+ALUOP_W-1:0] id_ctrl_i,
  input  logic                 flush_i,
  input  logic                 ex_hold_i,
  output logic                 ex_valid_o,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [XLEN-1:0]      ex_rdata1_o,
  output logic [XLEN-1:0]      ex_rdata2_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic [RADDR_W-1:0]   ex_rs1_o,
  output logic [RADDR_W-1:0]   ex_rs2_o,
  output logic [RADDR_W-1:0]   ex_rd_o,
  output logic [7+ALUOP_W-1:0] ex_ctrl_o,
  output logic                 id_stall_o,
  output logic [PERF_W-1:0]    bubble_cnt_o
);

  localparam int CTRL_W      = 7 + ALUOP_W;
  // Control layout is {regwrite,memread,memwrite,memtoreg,alusrc,branch,jump,aluop}
  localparam int MEMREAD_BIT = CTRL_W - 2;

  // What the EX register does on the next edge, in priority order
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_FLUSH  = 2'd1,
    UPD_HOLD   = 2'd2,
    UPD_BUBBLE = 2'd3
  } upd_e;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  upd_e upd;

  // Load-use detection: a load in EX whose rd feeds a source the ID instruction actually reads
  always_comb begin
    rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_o);
    rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_o);
    hazard  = id_valid_i && ex_valid_o && ex_ctrl_o[MEMREAD_BIT] &&
              (ex_rd_o != '0) && (rs1_hit || rs2_hit);
  end

  // Choose the update action; flush beats hold, hold beats hazard
  always_comb begin
    upd = UPD_LOAD;
    if (flush_i) begin
      upd = UPD_FLUSH;
    end else if (ex_hold_i) begin
      upd = UPD_HOLD;
    end else if (hazard) begin
      upd = UPD_BUBBLE;
    end
  end

  assign id_stall_o = (upd == UPD_HOLD) || (upd == UPD_BUBBLE);

  // EX register: load, freeze, or replace with a fully zeroed bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o  <= 1'b0;
      ex_pc_o     <= '0;
      ex_rdata1_o <= '0;
      ex_rdata2_o <= '0;
      ex_imm_o    <= '0;
      ex_rs1_o    <= '0;
      ex_rs2_o    <= '0;
      ex_rd_o     <= '0;
      ex_ctrl_o   <= '0;
    end else begin
      case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          ex_valid_o  <= 1'b0;
          ex_pc_o     <= '0;
          ex_rdata1_o <= '0;
          ex_rdata2_o <= '0;
          ex_imm_o    <= '0;
          ex_rs1_o    <= '0;
          ex_rs2_o    <= '0;
          ex_rd_o     <= '0;
          ex_ctrl_o   <= '0;
        end
        UPD_LOAD: begin
          ex_valid_o  <= id_valid_i;
          ex_pc_o     <= id_pc_i;
          ex_rdata1_o <= id_rdata1_i;
          ex_rdata2_o <= id_rdata2_i;
          ex_imm_o    <= id_imm_i;
          ex_rs1_o    <= id_rs1_i;
          ex_rs2_o    <= id_rs2_i;
          ex_rd_o     <= id_rd_i;
          ex_ctrl_o   <= id_valid_i ? id_ctrl_i : {CTRL_W{1'b0}};
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] bubble_cnt;

  // Count only the bubbles injected for load-use, not flushes or holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (upd == UPD_BUBBLE) begin
      bubble_cnt <= bubble_cnt + PERF_W'(1);
    end
  end

  assign bubble_cnt_o = bubble_cnt;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: self-checking bench for id_ex_pipe_reg.
// A directed vector table, hand-written hold and reset sequences, and randomized traffic,
// all checked against a behavioural model of the EX slot. Honours ID_EX_PERF_EN.
`timescale 1ns/1ps

module tb_id_ex_pipe_reg;

  localparam logic [10:0] C_ADD = 11'h400;
  localparam logic [10:0] C_LW  = 11'h6C0;
  localparam logic [10:0] C_SW  = 11'h140;

`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          use1;
    bit          use2;
    logic [4:0]  rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [10:0] ctrl;
    bit          flush;
    bit          hold;
  } in_t;

  typedef struct {
    in_t         in;
    bit          stall;
    bit          valid;
    logic [4:0]  rd;
    logic [10:0] ctrl;
    int unsigned cnt;
  } vec_t;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [10:0] ctrl;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid_i, id_use_rs1_i, id_use_rs2_i, flush_i, ex_hold_i;
  logic [31:0] id_pc_i, id_rdata1_i, id_rdata2_i, id_imm_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [10:0] id_ctrl_i;
  logic ex_valid_o, id_stall_o;
  logic [31:0] ex_pc_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o, bubble_cnt_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [10:0] ex_ctrl_o;

  int checks = 0;
  int failures = 0;
  ex_t m;
  int unsigned m_cnt;
  bit last_stall;
  vec_t vecs[15];

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i), .id_rdata1_i(id_rdata1_i),
    .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
    .flush_i(flush_i), .ex_hold_i(ex_hold_i), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_rdata1_o(ex_rdata1_o), .ex_rdata2_o(ex_rdata2_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_ctrl_o(ex_ctrl_o), .id_stall_o(id_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic in_t mkIn(input bit valid, input logic [4:0] rs1, input bit use1,
                               input logic [4:0] rs2, input bit use2, input logic [4:0] rd,
                               input logic [10:0] ctrl, input bit flush, input bit hold);
    in_t v;
    v.valid = valid; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
    v.rd = rd; v.ctrl = ctrl; v.flush = flush; v.hold = hold;
    v.pc = $urandom; v.r1 = $urandom; v.r2 = $urandom; v.imm = $urandom;
    return v;
  endfunction

  function automatic in_t randIn();
    in_t v;
    v = mkIn($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1 ? C_LW : 11'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3);
    return v;
  endfunction

  task automatic applyStimulus(input in_t v);
    id_valid_i = v.valid; id_pc_i = v.pc; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
    id_use_rs1_i = v.use1; id_use_rs2_i = v.use2; id_rd_i = v.rd;
    id_rdata1_i = v.r1; id_rdata2_i = v.r2; id_imm_i = v.imm; id_ctrl_i = v.ctrl;
    flush_i = v.flush; ex_hold_i = v.hold;
  endtask

  // Reference behaviour: is the ID instruction waiting on a load that is still in EX?
  function automatic bit modelStall(input in_t v);
    bit load_in_ex, needs;
    load_in_ex = m.valid && m.ctrl[9] && m.rd != 5'd0;
    needs = (v.use1 && v.rs1 == m.rd) || (v.use2 && v.rs2 == m.rd);
    if (v.flush) return 1'b0;
    return v.hold || (v.valid && load_in_ex && needs);
  endfunction

  task automatic modelReset();
    m = '{default: '0};
    m_cnt = 0;
  endtask

  task automatic modelUpdate(input in_t v);
    bit st;
    st = modelStall(v);
    if (v.flush || (st && !v.hold)) begin
      if (!v.flush) m_cnt++;
      m = '{default: '0};
    end else if (!v.hold) begin
      m.valid = v.valid; m.pc = v.pc; m.r1 = v.r1; m.r2 = v.r2; m.imm = v.imm;
      m.rs1 = v.rs1; m.rs2 = v.rs2; m.rd = v.rd;
      m.ctrl = v.valid ? v.ctrl : 11'd0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".valid"}, 64'(ex_valid_o), 64'(m.valid));
    checkVal({tag, ".pc"}, 64'(ex_pc_o), 64'(m.pc));
    checkVal({tag, ".rdata1"}, 64'(ex_rdata1_o), 64'(m.r1));
    checkVal({tag, ".rdata2"}, 64'(ex_rdata2_o), 64'(m.r2));
    checkVal({tag, ".imm"}, 64'(ex_imm_o), 64'(m.imm));
    checkVal({tag, ".rs1"}, 64'(ex_rs1_o), 64'(m.rs1));
    checkVal({tag, ".rs2"}, 64'(ex_rs2_o), 64'(m.rs2));
    checkVal({tag, ".rd"}, 64'(ex_rd_o), 64'(m.rd));
    checkVal({tag, ".ctrl"}, 64'(ex_ctrl_o), 64'(m.ctrl));
    checkVal({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), PERF ? 64'(m_cnt) : 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".valid"}, 64'(ex_valid_o), 64'd0);
    checkVal({tag, ".pc"}, 64'(ex_pc_o), 64'd0);
    checkVal({tag, ".data"}, {ex_rdata1_o, ex_rdata2_o}, 64'd0);
    checkVal({tag, ".imm"}, 64'(ex_imm_o), 64'd0);
    checkVal({tag, ".regs"}, 64'({ex_rs1_o, ex_rs2_o, ex_rd_o}), 64'd0);
    checkVal({tag, ".ctrl"}, 64'(ex_ctrl_o), 64'd0);
    checkVal({tag, ".stall"}, 64'(id_stall_o), 64'd0);
    checkVal({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'd0);
  endtask

  // One full cycle, entered and left at posedge+1
  task automatic runCycle(input in_t v, input string tag);
    applyStimulus(v);
    #3;
    last_stall = id_stall_o;
    checkVal({tag, ".stall"}, 64'(id_stall_o), 64'(modelStall(v)));
    @(posedge clk);
    #1;
    modelUpdate(v);
    checkOutput(tag);
  endtask

  initial begin
    in_t v, held;
    ex_t snap;
    modelReset();
    // Reset held with random traffic (no hold): everything stays 0
    for (int i = 0; i < 3; i++) begin
      v = randIn();
      v.hold = 1'b0;
      applyStimulus(v);
      @(posedge clk);
      #3;
      checkAllZero($sformatf("reset%0d", i));
    end
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 11'd0, 0, 0));
    id_pc_i = '0; id_rdata1_i = '0; id_rdata2_i = '0; id_imm_i = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: inputs plus hand-derived expectations
    vecs[0]  = '{mkIn(1, 1, 1, 2, 1, 3, C_ADD, 0, 0), 0, 1, 3, C_ADD, 0};
    vecs[1]  = '{mkIn(1, 1, 1, 0, 0, 5, C_LW, 0, 0), 0, 1, 5, C_LW, 0};
    vecs[2]  = '{mkIn(1, 5, 1, 7, 1, 6, C_ADD, 0, 0), 1, 0, 0, 11'd0, 1};
    vecs[3]  = '{mkIn(1, 5, 1, 7, 1, 6, C_ADD, 0, 0), 0, 1, 6, C_ADD, 1};
    vecs[4]  = '{mkIn(1, 2, 1, 0, 0, 0, C_LW, 0, 0), 0, 1, 0, C_LW, 1};
    vecs[5]  = '{mkIn(1, 0, 1, 0, 1, 1, C_ADD, 0, 0), 0, 1, 1, C_ADD, 1};
    vecs[6]  = '{mkIn(1, 1, 1, 0, 0, 5, C_LW, 0, 0), 0, 1, 5, C_LW, 1};
    vecs[7]  = '{mkIn(1, 2, 1, 5, 0, 8, C_ADD, 0, 0), 0, 1, 8, C_ADD, 1};
    vecs[8]  = '{mkIn(1, 8, 1, 0, 0, 9, C_LW, 0, 0), 0, 1, 9, C_LW, 1};
    vecs[9]  = '{mkIn(1, 9, 1, 0, 0, 10, C_ADD, 1, 1), 0, 0, 0, 11'd0, 1};
    vecs[10] = '{mkIn(1, 2, 1, 3, 1, 4, C_SW, 0, 0), 0, 1, 4, C_SW, 1};
    vecs[11] = '{mkIn(1, 4, 1, 0, 0, 11, C_ADD, 0, 0), 0, 1, 11, C_ADD, 1};
    vecs[12] = '{mkIn(0, 11, 1, 0, 0, 12, C_LW, 0, 0), 0, 0, 12, 11'd0, 1};
    vecs[13] = '{mkIn(1, 1, 1, 0, 0, 7, C_LW, 0, 0), 0, 1, 7, C_LW, 1};
    vecs[14] = '{mkIn(0, 7, 1, 0, 0, 3, C_ADD, 0, 0), 0, 0, 3, 11'd0, 1};
    for (int i = 0; i < 15; i++) begin
      runCycle(vecs[i].in, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.tstall", i), 64'(last_stall), 64'(vecs[i].stall));
      checkVal($sformatf("vec%0d.tvalid", i), 64'(ex_valid_o), 64'(vecs[i].valid));
      checkVal($sformatf("vec%0d.trd", i), 64'(ex_rd_o), 64'(vecs[i].rd));
      checkVal($sformatf("vec%0d.tctrl", i), 64'(ex_ctrl_o), 64'(vecs[i].ctrl));
      checkVal($sformatf("vec%0d.tcnt", i), 64'(bubble_cnt_o), PERF ? 64'(vecs[i].cnt) : 64'd0);
    end

    // Hold for three cycles: EX frozen, stall asserted, then the held instruction advances
    runCycle(mkIn(1, 1, 1, 2, 1, 13, C_ADD, 0, 0), "holdA");
    snap = m;
    held = mkIn(1, 2, 1, 3, 1, 14, C_ADD, 0, 1);
    for (int i = 0; i < 3; i++) begin
      runCycle(held, $sformatf("hold%0d", i));
      checkVal($sformatf("hold%0d.tstall", i), 64'(last_stall), 64'd1);
      checkVal($sformatf("hold%0d.frozen_pc", i), 64'(ex_pc_o), 64'(snap.pc));
      checkVal($sformatf("hold%0d.frozen_rd", i), 64'(ex_rd_o), 64'd13);
    end
    held.hold = 1'b0;
    runCycle(held, "holdRel");
    checkVal("holdRel.tstall", 64'(last_stall), 64'd0);
    checkVal("holdRel.trd", 64'(ex_rd_o), 64'd14);
    checkVal("holdRel.tpc", 64'(ex_pc_o), 64'(held.pc));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      runCycle(randIn(), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a load-use stall
    runCycle(mkIn(1, 1, 1, 0, 0, 5, C_LW, 0, 0), "arstLoad");
    v = mkIn(1, 5, 1, 7, 1, 6, C_ADD, 0, 0);
    applyStimulus(v);
    #2;
    checkVal("arst.pre_stall", 64'(id_stall_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("arst");
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runCycle(v, "arstAfter");
    checkVal("arstAfter.tstall", 64'(last_stall), 64'd0);
    checkVal("arstAfter.trd", 64'(ex_rd_o), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
